// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 CTR-mode front end.
package aes_pkg;

  typedef logic [127:0] aes_block_t;
  typedef logic [127:0] aes_key_t;
  typedef logic [7:0]   byte_t;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StLaunch,
    StWait,
    StOut
  } ctr_state_t;

  localparam int unsigned AES_CORE_LAT = 11;

endpackage

// File: rtl/aes_ctr_inc.sv
// Counter-block increment: low CTR_W bits wrap, upper bits pass through untouched.
module aes_ctr_inc
  import aes_pkg::*;
#(
  parameter int unsigned CTR_W = 32
) (
  input  aes_block_t ctr_i,
  output aes_block_t ctr_o
);

  if (CTR_W >= 128) begin : g_full
    assign ctr_o = ctr_i + 128'd1;
  end else begin : g_part
    assign ctr_o = {ctr_i[127:CTR_W], ctr_i[CTR_W-1:0] + CTR_W'(1)};
  end

endmodule

// File: rtl/aes_ctr_sequencer.sv
// CTR-mode sequencer: feeds counter blocks to an iterative AES-128 core, one block in
// flight, and XORs the returned keystream with buffered plaintext.
module aes_ctr_sequencer
  import aes_pkg::*;
#(
  parameter int unsigned CTR_W    = 32,
  parameter int unsigned CORE_LAT = AES_CORE_LAT,
  parameter int unsigned WDOG_SLK = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cfg_load_i,
  input  aes_key_t   cfg_key_i,
  input  aes_block_t cfg_iv_i,
  input  logic       pt_valid_i,
  output logic       pt_ready_o,
  input  aes_block_t pt_data_i,
  input  logic       pt_last_i,
  output logic       ct_valid_o,
  input  logic       ct_ready_i,
  output aes_block_t ct_data_o,
  output logic       ct_last_o,
  output logic       core_valid_o,
  output aes_block_t core_data_o,
  output aes_key_t   core_key_o,
  input  logic       core_res_valid_i,
  input  aes_block_t core_res_i,
  output logic       busy_o,
  output logic       err_o
);

  localparam int unsigned WdogMax = CORE_LAT + WDOG_SLK;
  localparam int unsigned WdogW   = $clog2(WdogMax + 1) + 1;

  ctr_state_t       state_q, state_d;
  aes_key_t         key_q, key_d;
  aes_block_t       ctr_q, ctr_d, ctr_inc;
  aes_block_t       pt_q, pt_d;
  logic             last_q, last_d;
  aes_block_t       ct_data_q, ct_data_d;
  logic             ct_last_q, ct_last_d;
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             err_q, err_d;

  aes_ctr_inc #(
    .CTR_W(CTR_W)
  ) u_inc (
    .ctr_i(ctr_q),
    .ctr_o(ctr_inc)
  );

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    ctr_d     = ctr_q;
    pt_d      = pt_q;
    last_d    = last_q;
    ct_data_d = ct_data_q;
    ct_last_d = ct_last_q;
    wdog_d    = wdog_q;
    err_d     = err_q;

    if (core_res_valid_i && (state_q != StWait)) err_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (cfg_load_i) begin
          key_d   = cfg_key_i;
          ctr_d   = cfg_iv_i;
          state_d = StArmed;
        end
      end
      StArmed: begin
        // A reload wins over a plaintext offered in the same cycle.
        if (cfg_load_i) begin
          key_d = cfg_key_i;
          ctr_d = cfg_iv_i;
        end else if (pt_valid_i) begin
          pt_d    = pt_data_i;
          last_d  = pt_last_i;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        ctr_d   = ctr_inc;
        // wdog holds the number of cycles elapsed since the launch cycle.
        wdog_d  = WdogW'(1);
        state_d = StWait;
      end
      StWait: begin
        if (core_res_valid_i) begin
          ct_data_d = core_res_i ^ pt_q;
          ct_last_d = last_q;
          state_d   = StOut;
        end else if (wdog_q >= WdogW'(WdogMax)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + WdogW'(1);
        end
      end
      StOut: begin
        if (ct_ready_i) state_d = last_q ? StIdle : StArmed;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StIdle;
      key_q     <= '0;
      ctr_q     <= '0;
      pt_q      <= '0;
      last_q    <= 1'b0;
      ct_data_q <= '0;
      ct_last_q <= 1'b0;
      wdog_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      ctr_q     <= ctr_d;
      pt_q      <= pt_d;
      last_q    <= last_d;
      ct_data_q <= ct_data_d;
      ct_last_q <= ct_last_d;
      wdog_q    <= wdog_d;
      err_q     <= err_d;
    end
  end

  assign pt_ready_o   = (state_q == StArmed) && !cfg_load_i;
  assign ct_valid_o   = (state_q == StOut);
  assign ct_data_o    = ct_data_q;
  assign ct_last_o    = ct_last_q;
  assign core_valid_o = (state_q == StLaunch);
  assign core_data_o  = ctr_q;
  assign core_key_o   = key_q;
  assign busy_o       = (state_q == StLaunch) || (state_q == StWait) || (state_q == StOut);
  assign err_o        = err_q;

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// Scoreboard bench for aes_ctr_sequencer with a fixed-latency behavioural stand-in for the AES core.
module tb_aes_ctr_sequencer;

  localparam int CoreLat = 11;
  localparam logic [127:0] Key1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] Iv1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Ct1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk, resetn;
  logic         cfg_load_i;
  logic [127:0] cfg_key_i, cfg_iv_i;
  logic         pt_valid_i, pt_ready_o, pt_last_i;
  logic [127:0] pt_data_i;
  logic         ct_valid_o, ct_ready_i, ct_last_o;
  logic [127:0] ct_data_o;
  logic         core_valid_o;
  logic [127:0] core_data_o, core_key_o;
  logic         core_res_valid_i;
  logic [127:0] core_res_i;
  logic         busy_o, err_o;

  logic         stub_vld, stub_hold, spur;
  logic [127:0] stub_res;
  int           stub_cnt;

  int n_err, n_chk, cyc, launch_cyc, launch_cnt;
  logic [127:0] exp_core_q[$];
  logic [128:0] exp_ct_q[$];
  int           acc_q[$];

  aes_ctr_sequencer dut (
    .clk             (clk),
    .resetn          (resetn),
    .cfg_load_i      (cfg_load_i),
    .cfg_key_i       (cfg_key_i),
    .cfg_iv_i        (cfg_iv_i),
    .pt_valid_i      (pt_valid_i),
    .pt_ready_o      (pt_ready_o),
    .pt_data_i       (pt_data_i),
    .pt_last_i       (pt_last_i),
    .ct_valid_o      (ct_valid_o),
    .ct_ready_i      (ct_ready_i),
    .ct_data_o       (ct_data_o),
    .ct_last_o       (ct_last_o),
    .core_valid_o    (core_valid_o),
    .core_data_o     (core_data_o),
    .core_key_o      (core_key_o),
    .core_res_valid_i(core_res_valid_i),
    .core_res_i      (core_res_i),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  assign core_res_valid_i = stub_vld | spur;
  assign core_res_i       = stub_res;

  // Keystream stand-in: the FIPS-197 vector where it applies, an easy hand function elsewhere.
  function automatic logic [127:0] ks(input logic [127:0] d, input logic [127:0] k);
    if (d == Iv1 && k == Key1) return Ct1;
    return d ^ ~k;
  endfunction

  task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Core stand-in: result valid exactly CoreLat cycles after the launch cycle.
  initial begin
    stub_cnt = -1;
    stub_vld = 1'b0;
    stub_res = '0;
    forever begin
      @(negedge clk);
      stub_vld = 1'b0;
      if (!resetn) stub_cnt = -1;
      else if (core_valid_o) begin
        stub_cnt = CoreLat - 1;
        stub_res = ks(core_data_o, core_key_o);
      end else if (stub_cnt > 0) stub_cnt--;
      else if (stub_cnt == 0) begin
        stub_cnt = -1;
        stub_vld = !stub_hold;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a launch or a ciphertext.
  initial begin
    logic         vprev;
    logic [127:0] ec;
    logic [128:0] et;
    int           ta;
    vprev = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (core_valid_o) begin
          launch_cyc = cyc;
          launch_cnt++;
          if (exp_core_q.size() == 0) fail_now("unexpected_launch");
          else begin
            ec = exp_core_q.pop_front();
            chk("core_data", {1'b0, core_data_o}, {1'b0, ec});
          end
        end
        if (ct_valid_o && !vprev) begin
          if (acc_q.size() == 0) fail_now("unexpected_ct_valid");
          else begin
            ta = acc_q.pop_front();
            chk("ct_latency", 129'(cyc - ta), 129'(13));
          end
        end
        if (ct_valid_o && ct_ready_i) begin
          if (exp_ct_q.size() == 0) fail_now("unexpected_ct");
          else begin
            et = exp_ct_q.pop_front();
            chk("ct_block", {ct_last_o, ct_data_o}, et);
          end
        end
      end
      vprev = ct_valid_o;
    end
  end

  task automatic cfg(input logic [127:0] key, input logic [127:0] iv);
    @(posedge clk);
    #1 cfg_load_i = 1'b1;
    cfg_key_i = key;
    cfg_iv_i  = iv;
    @(posedge clk);
    #1 cfg_load_i = 1'b0;
  endtask

  task automatic send_pt(input logic [127:0] pt, input logic last, input logic [127:0] ctr,
                         input logic [127:0] key, input bit want_ct);
    bit done;
    done = 1'b0;
    @(posedge clk);
    #1 pt_valid_i = 1'b1;
    pt_data_i = pt;
    pt_last_i = last;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (pt_ready_o) begin
        done = 1'b1;
        exp_core_q.push_back(ctr);
        if (want_ct) begin
          exp_ct_q.push_back({last, pt ^ ks(ctr, key)});
          acc_q.push_back(cyc);
        end
      end
    end
    if (!done) fail_now("pt_accept");
    @(posedge clk);
    #1 pt_valid_i = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (exp_ct_q.size() == 0 && !busy_o) done = 1'b1;
    end
    if (!done) fail_now("drain");
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    int bad;
    int lc0;
    bit seen;
    n_err = 0; n_chk = 0; launch_cnt = 0; launch_cyc = 0;
    resetn = 1'b0; cfg_load_i = 1'b0; cfg_key_i = '0; cfg_iv_i = '0;
    pt_valid_i = 1'b0; pt_data_i = '0; pt_last_i = 1'b0; ct_ready_i = 1'b1;
    stub_hold = 1'b0; spur = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 129'({pt_ready_o, ct_valid_o, ct_last_o, core_valid_o, busy_o, err_o}), '0);
    chk("reset_ct_data", {1'b0, ct_data_o}, '0);
    chk("reset_key", {1'b0, core_key_o}, '0);
    #1 resetn = 1'b1;

    // 1: FIPS-197 block, single last block.
    cfg(Key1, Iv1);
    send_pt('0, 1'b1, Iv1, Key1, 1'b1);
    drain();
    chk("t1_idle_ready", 129'({pt_ready_o, busy_o, err_o}), '0);

    // 2: round-trip first block back to zero, then the incremented counter.
    cfg(Key1, Iv1);
    send_pt(Ct1, 1'b0, Iv1, Key1, 1'b1);
    send_pt(128'hdeadbeef_00000000_cafef00d_12345678, 1'b1,
            128'h00112233445566778899aabbccddef00, Key1, 1'b1);
    drain();

    // 3: low 32-bit counter wrap.
    cfg(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hf0f1f2f3f4f5f6f7f8f9fafbffffffff);
    send_pt(128'h1, 1'b0, 128'hf0f1f2f3f4f5f6f7f8f9fafbffffffff,
            128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
    send_pt(128'h2, 1'b1, 128'hf0f1f2f3f4f5f6f7f8f9fafb00000000,
            128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
    drain();
    chk("t3_no_err", {128'b0, err_o}, '0);

    // 4: backpressure for 20 cycles with a plaintext waiting.
    cfg(128'h55aa55aa55aa55aa55aa55aa55aa55aa, 128'h00000000000000000000000000000010);
    ct_ready_i = 1'b0;
    send_pt(128'h0123456789abcdef0123456789abcdef, 1'b0, 128'h10,
            128'h55aa55aa55aa55aa55aa55aa55aa55aa, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ct_valid_o) seen = 1'b1;
    end
    if (!seen) fail_now("t4_ct_valid");
    @(posedge clk);
    #1 pt_valid_i = 1'b1;
    pt_data_i = 128'hffff;
    pt_last_i = 1'b1;
    bad = 0;
    lc0 = launch_cnt;
    repeat (20) begin
      @(negedge clk);
      if (ct_data_o !== (128'h0123456789abcdef0123456789abcdef ^ 128'h10 ^
                         ~128'h55aa55aa55aa55aa55aa55aa55aa55aa)) bad++;
      if (!ct_valid_o || pt_ready_o) bad++;
    end
    chk("t4_stall_stable", 129'(bad), '0);
    chk("t4_no_launch", 129'(launch_cnt - lc0), '0);
    @(posedge clk);
    #1 pt_valid_i = 1'b0;
    ct_ready_i = 1'b1;
    send_pt(128'h77, 1'b1, 128'h11, 128'h55aa55aa55aa55aa55aa55aa55aa55aa, 1'b1);
    drain();

    // 5: reload beats a simultaneous plaintext.
    cfg(128'h1111, 128'h2222);
    @(posedge clk);
    #1 cfg_load_i = 1'b1;
    cfg_key_i = 128'habcd0000;
    cfg_iv_i = 128'h9999_0000_0000_0005;
    pt_valid_i = 1'b1;
    pt_data_i = 128'h4242;
    pt_last_i = 1'b1;
    @(negedge clk);
    chk("t5_ready_low", {128'b0, pt_ready_o}, '0);
    @(posedge clk);
    #1 cfg_load_i = 1'b0;
    pt_valid_i = 1'b0;
    send_pt(128'h4242, 1'b1, 128'h9999_0000_0000_0005, 128'habcd0000, 1'b1);
    drain();

    // 6a: core result withheld -> watchdog.
    cfg(Key1, 128'h5);
    stub_hold = 1'b1;
    send_pt(128'h3, 1'b1, 128'h5, Key1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (err_o) begin
        seen = 1'b1;
        chk("t6_wdog_latency", 129'(cyc - launch_cyc), 129'(14));
        chk("t6_wdog_idle", 129'({busy_o, pt_ready_o}), '0);
      end
    end
    if (!seen) fail_now("t6_wdog_err");
    stub_hold = 1'b0;
    pulse_reset();
    @(negedge clk);
    chk("t6_err_cleared", {128'b0, err_o}, '0);

    // 6b: spurious result while armed.
    cfg(Key1, 128'h6);
    @(posedge clk);
    #1 spur = 1'b1;
    @(posedge clk);
    #1 spur = 1'b0;
    @(negedge clk);
    chk("t6_spurious", 129'({err_o, pt_ready_o}), 129'(2'b11));
    pulse_reset();

    // 6c: reset while waiting on the core.
    cfg(Key1, 128'h7);
    send_pt(128'h8, 1'b1, 128'h7, Key1, 1'b0);
    repeat (4) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_ctrl", 129'({pt_ready_o, ct_valid_o, ct_last_o, core_valid_o, busy_o, err_o}), '0);
    chk("t6_rst_data", {1'b0, ct_data_o | core_key_o | core_data_o}, '0);
    resetn = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (ct_valid_o || err_o || busy_o) bad++;
    end
    chk("t6_rst_quiet", 129'(bad), '0);

    chk("sb_empty", 129'(exp_ct_q.size() + exp_core_q.size() + acc_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
